// File: rtl/cordic_phase_detect_if.sv
// Sample-in / result-out handshake bundle for the CORDIC phase detector.
// The DUT uses the slave modport; whoever feeds samples and takes results uses master.
interface cordic_phase_detect_if #(
   parameter int DATA_W = 16
);
   logic signed [DATA_W-1:0] in_i;
   logic signed [DATA_W-1:0] in_q;
   logic                     in_valid;
   logic                     in_ready;
   logic [31:0]              phase;
   logic [DATA_W+1:0]        mag;
   logic                     out_valid;
   logic                     out_ready;

   modport slave (
      input  in_i, in_q, in_valid, out_ready,
      output in_ready, phase, mag, out_valid
   );

   modport master (
      output in_i, in_q, in_valid, out_ready,
      input  in_ready, phase, mag, out_valid
   );
endinterface

// File: rtl/cordic_phase_detect.sv
// Iterative vectoring-mode CORDIC: recovers phase (2^32 LSB per turn) and scaled magnitude
// from a signed I/Q pair, one micro-rotation per clock.
//
//   state  | meaning
//   S_IDLE | waiting for a sample, in_ready high
//   S_ROT  | micro-rotations k=0..ITER-1, then one cycle to latch phase/mag
//   S_DONE | result presented, out_valid high until out_ready
module cordic_phase_detect #(
   parameter int DATA_W = 16,
   parameter int ITER   = 16
) (
   input logic                   clk,
   input logic                   reset,
   cordic_phase_detect_if.slave  bus
);

   localparam int         XW     = DATA_W + 3;
   localparam logic [4:0] K_LAST = 5'(ITER);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROT,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic signed [XW-1:0]  r_x;
   logic signed [XW-1:0]  r_y;
   logic [31:0]           r_z;
   logic [4:0]            r_k;
   logic                  r_zero;
   logic [31:0]           r_phase;
   logic [DATA_W+1:0]     r_mag;

   logic                  w_in_ready;
   logic                  w_out_valid;
   logic                  w_start;
   logic                  w_last;
   logic                  w_d;
   logic signed [XW-1:0]  w_i_ext;
   logic signed [XW-1:0]  w_q_ext;
   logic signed [XW-1:0]  w_x_sh;
   logic signed [XW-1:0]  w_y_sh;
   logic [31:0]           w_atan;

   // round(atan(2^-k) / (2*pi) * 2^32)
   function automatic logic [31:0] atan_lut(input logic [4:0] k);
      case (k)
         5'd0:    atan_lut = 32'h2000_0000;
         5'd1:    atan_lut = 32'h12E4_051E;
         5'd2:    atan_lut = 32'h09FB_385B;
         5'd3:    atan_lut = 32'h0511_11D4;
         5'd4:    atan_lut = 32'h028B_0D43;
         5'd5:    atan_lut = 32'h0145_D7E1;
         5'd6:    atan_lut = 32'h00A2_F61E;
         5'd7:    atan_lut = 32'h0051_7C55;
         5'd8:    atan_lut = 32'h0028_BE53;
         5'd9:    atan_lut = 32'h0014_5F2F;
         5'd10:   atan_lut = 32'h000A_2F98;
         5'd11:   atan_lut = 32'h0005_17CC;
         5'd12:   atan_lut = 32'h0002_8BE6;
         5'd13:   atan_lut = 32'h0001_45F3;
         5'd14:   atan_lut = 32'h0000_A2FA;
         5'd15:   atan_lut = 32'h0000_517D;
         5'd16:   atan_lut = 32'h0000_28BE;
         5'd17:   atan_lut = 32'h0000_145F;
         5'd18:   atan_lut = 32'h0000_0A30;
         5'd19:   atan_lut = 32'h0000_0518;
         5'd20:   atan_lut = 32'h0000_028C;
         5'd21:   atan_lut = 32'h0000_0146;
         5'd22:   atan_lut = 32'h0000_00A3;
         5'd23:   atan_lut = 32'h0000_0051;
         default: atan_lut = 32'h0000_0000;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = S_ROT;
         end
         S_ROT: begin
            if (r_k == K_LAST) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_start = (r_state == S_IDLE) && bus.in_valid;
   assign w_last  = (r_state == S_ROT) && (r_k == K_LAST);
   assign w_i_ext = {{3{bus.in_i[DATA_W-1]}}, bus.in_i};
   assign w_q_ext = {{3{bus.in_q[DATA_W-1]}}, bus.in_q};
   assign w_d     = ~r_y[XW-1];
   assign w_x_sh  = r_x >>> r_k;
   assign w_y_sh  = r_y >>> r_k;
   assign w_atan  = atan_lut(r_k);

   // Left-half-plane inputs are pre-rotated by 180 deg so the iterations only cover +-90 deg.
   // An all-zero input would otherwise collect the sum of the ATAN table, hence r_zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_k     <= '0;
         r_zero  <= 1'b0;
         r_phase <= '0;
         r_mag   <= '0;
      end else if (w_start) begin
         r_k    <= '0;
         r_zero <= (bus.in_i == '0) && (bus.in_q == '0);
         if (bus.in_i[DATA_W-1]) begin
            r_x <= -w_i_ext;
            r_y <= -w_q_ext;
            r_z <= 32'h8000_0000;
         end else begin
            r_x <= w_i_ext;
            r_y <= w_q_ext;
            r_z <= 32'h0000_0000;
         end
      end else if (w_last) begin
         r_phase <= r_zero ? 32'h0000_0000 : r_z;
         r_mag   <= r_x[DATA_W+1:0];
      end else if (r_state == S_ROT) begin
         if (w_d) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
         end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
         end
         r_k <= r_k + 5'd1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.phase     = r_phase;
   assign bus.mag       = r_mag;

endmodule

// File: tb/tb_cordic_phase_detect.sv
// Directed plus randomized bench for cordic_phase_detect against an atan2/sqrt model.
module tb_cordic_phase_detect;

   localparam int    DATA_W = 16;
   localparam int    ITER   = 16;
   localparam real   PI     = 3.14159265358979323846;
   localparam real   GAIN   = 1.6468;
   localparam longint TOL   = 64'd131072;
   localparam longint TOL_DDS = 64'd8388608;

   logic clk;
   logic reset;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   cordic_phase_detect_if #(.DATA_W(DATA_W)) bus ();

   cordic_phase_detect #(
      .DATA_W (DATA_W),
      .ITER   (ITER)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, required finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] ref_phase(input int vi, input int vq);
      real t;
      if (vi == 0 && vq == 0) return 32'h0;
      t = $atan2(real'(vq), real'(vi)) / (2.0 * PI);
      if (t < 0.0) t = t + 1.0;
      return 32'(longint'(t * 4294967296.0) & 64'hFFFF_FFFF);
   endfunction

   function automatic real ref_mag(input int vi, input int vq);
      return GAIN * $sqrt(real'(vi) * real'(vi) + real'(vq) * real'(vq));
   endfunction

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_phase(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                            input longint tol);
      logic [31:0] d;
      longint      du;
      longint      a;
      d  = obs - exp;
      du = longint'(d);
      a  = d[31] ? (64'sd4294967296 - du) : du;
      n_cmp++;
      assert ((a <= tol) === 1'b1) else begin
         n_bad++;
         $error("FAIL %s: phase observed 0x%08h expected 0x%08h err %0d tol %0d",
                tag, obs, exp, a, tol);
      end
   endtask

   task automatic chk_mag(input string tag, input logic [DATA_W+1:0] obs, input int vi, input int vq);
      real e;
      real dev;
      e   = ref_mag(vi, vq);
      dev = real'(obs) - e;
      if (dev < 0.0) dev = -dev;
      n_cmp++;
      assert ((dev <= 0.01 * e) === 1'b1) else begin
         n_bad++;
         $error("FAIL %s: mag observed %0d expected %0d (+-1%%)", tag, obs, int'(e));
      end
   endtask

   // Called and returns at #1 after a rising edge; out_ready is left as the caller set it.
   task automatic xact(input int vi, input int vq, output logic [31:0] ph,
                       output logic [DATA_W+1:0] mg, output int acc_cyc, output int done_cyc);
      int n;
      bus.in_i     = DATA_W'(vi);
      bus.in_q     = DATA_W'(vq);
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      done_cyc = cyc;
      ph       = bus.phase;
      mg       = bus.mag;
      chk_eq("out_valid_timeout", bus.out_valid, 64'd1);
   endtask

   task automatic check_vec(input string tag, input int vi, input int vq,
                            input logic [31:0] exp_ph, input longint tol);
      logic [31:0]       ph;
      logic [DATA_W+1:0] mg;
      int                a_c;
      int                d_c;
      xact(vi, vq, ph, mg, a_c, d_c);
      if (vi == 0 && vq == 0) begin
         chk_eq({tag, "_phase"}, ph, 64'd0);
         chk_eq({tag, "_mag"}, mg, 64'd0);
      end else begin
         chk_phase({tag, "_phase"}, ph, exp_ph, tol);
         chk_mag({tag, "_mag"}, mg, vi, vq);
      end
   endtask

   initial begin
      logic [31:0]       ph;
      logic [DATA_W+1:0] mg;
      logic [31:0]       exp_ph;
      logic [31:0]       acc;
      int                a_c;
      int                d_c;
      int                n;
      int                cnt;
      int                vi;
      int                vq;
      real               ang;
      real               rad;

      n_cmp        = 0;
      n_bad        = 0;
      reset        = 1'b1;
      bus.in_i     = '0;
      bus.in_q     = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_eq("reset_out_valid", bus.out_valid, 64'd0);
      chk_eq("reset_phase", bus.phase, 64'd0);
      chk_eq("reset_mag", bus.mag, 64'd0);
      chk_eq("reset_in_ready", bus.in_ready, 64'd1);
      repeat (2) @(posedge clk);
      #1;

      // latency and single-cycle out_valid with out_ready held high
      xact(16384, 0, ph, mg, a_c, d_c);
      chk_eq("latency", 64'(d_c - a_c), 64'(ITER + 1));
      chk_phase("axis0_phase", ph, 32'h0000_0000, TOL);
      chk_mag("axis0_mag", mg, 16384, 0);
      @(posedge clk); #1;
      chk_eq("out_valid_one_cycle", bus.out_valid, 64'd0);
      chk_eq("in_ready_back", bus.in_ready, 64'd1);

      check_vec("axis90", 0, 16384, 32'h4000_0000, TOL);
      check_vec("axis180", -16384, 0, 32'h8000_0000, TOL);
      check_vec("axis270", 0, -16384, 32'hC000_0000, TOL);
      check_vec("diag45", 11585, 11585, 32'h2000_0000, TOL);
      check_vec("diag225", -11585, -11585, 32'hA000_0000, TOL);
      check_vec("diag315", 11585, -11585, 32'hE000_0000, TOL);
      check_vec("zero", 0, 0, 32'h0, TOL);

      check_vec("fs_neg_neg", -32768, -32768, ref_phase(-32768, -32768), TOL);
      chk_eq("fs_neg_neg_quadrant", bus.phase[31:30], 64'(2'b10));
      check_vec("fs_pos_neg", 32767, -32768, ref_phase(32767, -32768), TOL);
      chk_eq("fs_pos_neg_quadrant", bus.phase[31:30], 64'(2'b11));

      // backpressure, with stray in_valid pulses during ROT and DONE
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      exp_ph        = ref_phase(20000, -7000);
      bus.in_i      = 16'sd20000;
      bus.in_q      = -16'sd7000;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rot_in_ready_low", bus.in_ready, 64'd0);
      bus.in_i     = -16'sd5;
      bus.in_q     = 16'sd7;
      bus.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      chk_eq("bp_out_valid", bus.out_valid, 64'd1);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         chk_eq("bp_hold_valid", bus.out_valid, 64'd1);
         chk_eq("bp_hold_in_ready", bus.in_ready, 64'd0);
         chk_phase("bp_hold_phase", bus.phase, exp_ph, TOL);
         chk_mag("bp_hold_mag", bus.mag, 20000, -7000);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk_eq("bp_release_valid", bus.out_valid, 64'd0);
      chk_eq("bp_release_in_ready", bus.in_ready, 64'd1);
      cnt = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) cnt++;
      end
      chk_eq("bp_no_extra_result", 64'(cnt), 64'd0);
      chk_phase("phase_kept", bus.phase, exp_ph, TOL);

      // reset in the middle of ROT discards the result
      bus.in_i     = -16'sd12000;
      bus.in_q     = 16'sd9000;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_eq("rst_rot_out_valid", bus.out_valid, 64'd0);
      chk_eq("rst_rot_phase", bus.phase, 64'd0);
      chk_eq("rst_rot_mag", bus.mag, 64'd0);
      chk_eq("rst_rot_in_ready", bus.in_ready, 64'd1);
      cnt = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) cnt++;
      end
      chk_eq("rst_rot_discarded", 64'(cnt), 64'd0);

      // DDS loopback: i/q from the accumulator phase, result compared with the accumulator
      acc = 32'h0;
      for (int s = 0; s < 20; s++) begin
         acc = acc + 32'h0123_4567 * 32'($urandom_range(1, 60));
         ang = 2.0 * PI * real'(acc) / 4294967296.0;
         vi  = int'(32767.0 * $cos(ang));
         vq  = int'(32767.0 * $sin(ang));
         check_vec($sformatf("dds%0d", s), vi, vq, acc, TOL_DDS);
      end

      // back-to-back random vectors of large amplitude
      for (int v = 0; v < 100; v++) begin
         ang = 2.0 * PI * real'($urandom) / 4294967296.0;
         rad = real'($urandom_range(16384, 32000));
         vi  = int'(rad * $cos(ang));
         vq  = int'(rad * $sin(ang));
         check_vec($sformatf("rand%0d", v), vi, vq, ref_phase(vi, vq), TOL);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
